trap_ctrl: RTL and testbench

Machine-mode trap sequencer that drives the write-back-stage CSR file. It arbitrates exceptions, `mret`, and three interrupt lines (external, software, timer), then issues the one-cycle CSR update strobes (mcause/mepc/mtval/mstatus). It also provides a pipeline kill/flush and a PC redirect to the trap vector or to `mepc`. It sits beside the CSR file in WB and talks to the fetch PC mux and the pipeline flush network.

---
 rtl/trap_ctrl_pkg.sv | 45 ++++
 rtl/trap_ctrl_if.sv | 60 ++++++
 rtl/trap_ctrl_irq_sync.sv | 32 +++
 rtl/trap_ctrl.sv | 175 +++++++++++++++++
 tb/tb_trap_ctrl.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/trap_ctrl_pkg.sv
`default_nettype none
//==============================================================================
// Module   : trap_ctrl_pkg
// Desc     : FSM encodings, trap cause codes and helpers for the trap sequencer.
// Revision : 1.0 - initial release
//==============================================================================
package trap_ctrl_pkg;

    typedef logic [1:0] trap_state_t;

    localparam trap_state_t ST_IDLE   = 2'd0;
    localparam trap_state_t ST_ENTER  = 2'd1;
    localparam trap_state_t ST_VECTOR = 2'd2;
    localparam trap_state_t ST_RETURN = 2'd3;

    localparam logic [3:0] TRAP_CAUSE_MEI = 4'd11;
    localparam logic [3:0] TRAP_CAUSE_MSI = 4'd3;
    localparam logic [3:0] TRAP_CAUSE_MTI = 4'd7;

    localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

    // Bit positions inside the packed {ext, sw, timer} request vector
    localparam int C_IRQ_EXT = 2;
    localparam int C_IRQ_SW  = 1;
    localparam int C_IRQ_TMR = 0;

    typedef struct packed {
        logic       ie_type;
        logic [3:0] code;
    } trap_cause_t;

    // Fixed-priority encoder: external > software > timer
    function automatic logic [3:0] irq_cause(input logic [2:0] irq);
        logic [3:0] code;
        code = TRAP_CAUSE_MTI;
        if (irq[C_IRQ_EXT]) begin
            code = TRAP_CAUSE_MEI;
        end else if (irq[C_IRQ_SW]) begin
            code = TRAP_CAUSE_MSI;
        end
        return code;
    endfunction

endpackage : trap_ctrl_pkg
`default_nettype wire

// File: rtl/trap_ctrl_if.sv
`default_nettype none
//==============================================================================
// Module   : trap_ctrl_if
// Desc     : Bundle between WB stage / CSR file / fetch and the trap sequencer.
// Revision : 1.0 - initial release
//==============================================================================
interface trap_ctrl_if #(
    parameter int XLEN = 32
);
    // Event and context inputs
    logic            exc_valid_i;
    logic [3:0]      exc_code_i;
    logic [XLEN-1:0] exc_pc_i;
    logic [XLEN-1:0] exc_tval_i;
    logic            mret_i;
    logic            wb_valid_i;
    logic [XLEN-1:0] wb_pc_i;
    logic            irq_ext_i;
    logic            irq_sw_i;
    logic            irq_timer_i;
    logic            mstatus_mie_i;
    logic [XLEN-1:0] mtvec_i;
    logic [XLEN-1:0] mepc_i;

    // CSR strobes, flush and redirect outputs
    logic            kill_wb_o;
    logic            set_mcause_o;
    logic            set_mepc_o;
    logic            set_mtval_o;
    logic            ecall_en_o;
    logic            mret_en_o;
    logic            ie_type_o;
    logic [3:0]      exception_code_o;
    logic [XLEN-1:0] epc_o;
    logic [XLEN-1:0] mtval_o;
    logic            flush_o;
    logic            redirect_valid_o;
    logic [XLEN-1:0] redirect_pc_o;
    logic            busy_o;

    modport master (
        output exc_valid_i, exc_code_i, exc_pc_i, exc_tval_i, mret_i,
               wb_valid_i, wb_pc_i, irq_ext_i, irq_sw_i, irq_timer_i,
               mstatus_mie_i, mtvec_i, mepc_i,
        input  kill_wb_o, set_mcause_o, set_mepc_o, set_mtval_o, ecall_en_o,
               mret_en_o, ie_type_o, exception_code_o, epc_o, mtval_o,
               flush_o, redirect_valid_o, redirect_pc_o, busy_o
    );

    modport slave (
        input  exc_valid_i, exc_code_i, exc_pc_i, exc_tval_i, mret_i,
               wb_valid_i, wb_pc_i, irq_ext_i, irq_sw_i, irq_timer_i,
               mstatus_mie_i, mtvec_i, mepc_i,
        output kill_wb_o, set_mcause_o, set_mepc_o, set_mtval_o, ecall_en_o,
               mret_en_o, ie_type_o, exception_code_o, epc_o, mtval_o,
               flush_o, redirect_valid_o, redirect_pc_o, busy_o
    );

endinterface : trap_ctrl_if
`default_nettype wire

// File: rtl/trap_ctrl_irq_sync.sv
`default_nettype none
//==============================================================================
// Module   : irq_sync
// Desc     : Parameterized-width two-flop synchronizer, async active-low reset.
// Revision : 1.0 - initial release
//==============================================================================
module irq_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule : irq_sync
`default_nettype wire

// File: rtl/trap_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : trap_ctrl
// Desc     : Machine-mode trap sequencer beside the WB-stage CSR file.
//            Optional macro TRAP_VECTORED_EN enables vectored interrupt targets.
// Revision : 1.0 - initial release
//==============================================================================
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    trap_ctrl_if.slave bus
);

    trap_state_t     r_state;
    trap_state_t     w_state_nxt;

    logic [2:0]      w_irq_sync;
    logic            w_idle;
    logic            w_irq_req;
    logic            w_take_exc;
    logic            w_take_mret;
    logic            w_take_irq;
    logic            w_accept;

    trap_cause_t     r_cause;
    logic [XLEN-1:0] r_epc;
    logic [XLEN-1:0] r_tval;

    logic [XLEN-1:0] w_base;
    logic [XLEN-1:0] w_target;

    logic            w_enter_stb;
    logic            w_mret_en;
    logic            w_flush;
    logic            w_redir_valid;
    logic [XLEN-1:0] w_redir_pc;

    irq_sync #(
        .WIDTH (3)
    ) u_irq_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({bus.irq_ext_i, bus.irq_sw_i, bus.irq_timer_i}),
        .q     (w_irq_sync)
    );

    // Accept decode: exception beats mret beats interrupt; nothing is taken while busy
    assign w_idle      = (r_state == ST_IDLE);
    assign w_irq_req   = bus.mstatus_mie_i && bus.wb_valid_i && (|w_irq_sync);
    assign w_take_exc  = w_idle && bus.exc_valid_i;
    assign w_take_mret = w_idle && !bus.exc_valid_i && bus.mret_i;
    assign w_take_irq  = w_idle && !bus.exc_valid_i && !bus.mret_i && w_irq_req;
    assign w_accept    = w_take_exc || w_take_mret || w_take_irq;

    //--------------------------------------------------------------------------
    // FSM state register
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    //--------------------------------------------------------------------------
    // FSM next-state logic
    //--------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_take_mret) begin
                    w_state_nxt = ST_RETURN;
                end else if (w_take_exc || w_take_irq) begin
                    w_state_nxt = ST_ENTER;
                end
            end
            ST_ENTER:  w_state_nxt = ST_VECTOR;
            ST_VECTOR: w_state_nxt = ST_IDLE;
            ST_RETURN: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    //--------------------------------------------------------------------------
    // Trap context latched at accept; mret leaves it untouched
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cause <= '0;
            r_epc   <= '0;
            r_tval  <= '0;
        end else if (w_take_exc) begin
            r_cause <= '{ie_type: 1'b0, code: bus.exc_code_i};
            r_epc   <= bus.exc_pc_i;
            r_tval  <= bus.exc_tval_i;
        end else if (w_take_irq) begin
            r_cause <= '{ie_type: 1'b1, code: irq_cause(w_irq_sync)};
            r_epc   <= bus.wb_pc_i;
            r_tval  <= '0;
        end
    end

    //--------------------------------------------------------------------------
    // Trap target: base, or base + 4*cause for interrupts in vectored mode
    //--------------------------------------------------------------------------
    assign w_base = {bus.mtvec_i[XLEN-1:2], 2'b00};

`ifdef TRAP_VECTORED_EN
    always_comb begin
        w_target = w_base;
        if (r_cause.ie_type && (bus.mtvec_i[1:0] == MTVEC_MODE_VECTORED)) begin
            w_target = w_base + {{(XLEN-6){1'b0}}, r_cause.code, 2'b00};
        end
    end
`else
    logic w_unused_mode;
    assign w_unused_mode = ^bus.mtvec_i[1:0];
    assign w_target      = w_base;
`endif

    //--------------------------------------------------------------------------
    // FSM outputs: pure state decodes
    //--------------------------------------------------------------------------
    always_comb begin
        w_enter_stb   = 1'b0;
        w_mret_en     = 1'b0;
        w_flush       = 1'b0;
        w_redir_valid = 1'b0;
        w_redir_pc    = '0;
        case (r_state)
            ST_ENTER: begin
                w_enter_stb = 1'b1;
                w_flush     = 1'b1;
            end
            ST_VECTOR: begin
                w_flush       = 1'b1;
                w_redir_valid = 1'b1;
                w_redir_pc    = w_target;
            end
            ST_RETURN: begin
                w_mret_en     = 1'b1;
                w_flush       = 1'b1;
                w_redir_valid = 1'b1;
                w_redir_pc    = bus.mepc_i;
            end
            default: begin
                w_enter_stb = 1'b0;
            end
        endcase
    end

    // kill is the only combinational output; held low while reset is asserted
    assign bus.kill_wb_o        = w_accept && rst_n;
    assign bus.set_mcause_o     = w_enter_stb;
    assign bus.set_mepc_o       = w_enter_stb;
    assign bus.set_mtval_o      = w_enter_stb;
    assign bus.ecall_en_o       = w_enter_stb;
    assign bus.mret_en_o        = w_mret_en;
    assign bus.ie_type_o        = r_cause.ie_type;
    assign bus.exception_code_o = r_cause.code;
    assign bus.epc_o            = r_epc;
    assign bus.mtval_o          = r_tval;
    assign bus.flush_o          = w_flush;
    assign bus.redirect_valid_o = w_redir_valid;
    assign bus.redirect_pc_o    = w_redir_pc;
    assign bus.busy_o           = !w_idle;

endmodule : trap_ctrl
`default_nettype wire

// File: tb/tb_trap_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : tb_trap_ctrl
// Desc     : Directed, table-driven self-checking bench for trap_ctrl.
// Revision : 1.0 - initial release
//==============================================================================
module tb_trap_ctrl;

    typedef struct packed {
        logic        exc_valid;
        logic [3:0]  exc_code;
        logic [31:0] exc_pc;
        logic [31:0] exc_tval;
        logic        mret;
        logic        wb_valid;
        logic [31:0] wb_pc;
        logic [2:0]  irq;      // {ext, sw, timer}
        logic        mie;
        logic [31:0] mtvec;
        logic [31:0] mepc;
    } in_t;

    typedef struct packed {
        logic        kill;
        logic [3:0]  ent;      // {set_mcause, set_mepc, set_mtval, ecall_en}
        logic        mret_en;
        logic        flush;
        logic        redir;
        logic [31:0] rpc;
        logic        busy;
    } ctl_t;

    typedef struct packed {
        logic        chk;
        logic        ie;
        logic [3:0]  code;
        logic [31:0] epc;
        logic [31:0] tval;
    } dat_t;

    typedef struct {
        string name;
        in_t   i;
        ctl_t  c;
        dat_t  d;
    } vec_t;

`ifdef TRAP_VECTORED_EN
    localparam logic [31:0] C_TMR_TGT = 32'h0000_021C;
`else
    localparam logic [31:0] C_TMR_TGT = 32'h0000_0200;
`endif

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    trap_ctrl_if #(.XLEN(32)) bus ();

    trap_ctrl #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic in_t ev(input logic e, input logic [3:0] code, input logic [31:0] pc,
                               input logic [31:0] tval, input logic m, input logic wbv,
                               input logic [31:0] wbpc, input logic [2:0] irq, input logic mie,
                               input logic [31:0] mtvec);
        in_t r;
        r.exc_valid = e;    r.exc_code = code; r.exc_pc = pc;   r.exc_tval = tval;
        r.mret      = m;    r.wb_valid = wbv;  r.wb_pc  = wbpc; r.irq      = irq;
        r.mie       = mie;  r.mtvec    = mtvec; r.mepc  = 32'h104;
        return r;
    endfunction

    function automatic ctl_t ct(input logic k, input logic [3:0] ent, input logic m,
                                input logic f, input logic rd, input logic [31:0] rpc,
                                input logic b);
        ctl_t r;
        r.kill = k; r.ent = ent; r.mret_en = m; r.flush = f;
        r.redir = rd; r.rpc = rpc; r.busy = b;
        return r;
    endfunction

    function automatic dat_t dt(input logic c, input logic ie, input logic [3:0] code,
                                input logic [31:0] epc, input logic [31:0] tval);
        dat_t r;
        r.chk = c; r.ie = ie; r.code = code; r.epc = epc; r.tval = tval;
        return r;
    endfunction

    task automatic apply(input in_t i);
        bus.exc_valid_i   = i.exc_valid;
        bus.exc_code_i    = i.exc_code;
        bus.exc_pc_i      = i.exc_pc;
        bus.exc_tval_i    = i.exc_tval;
        bus.mret_i        = i.mret;
        bus.wb_valid_i    = i.wb_valid;
        bus.wb_pc_i       = i.wb_pc;
        bus.irq_ext_i     = i.irq[2];
        bus.irq_sw_i      = i.irq[1];
        bus.irq_timer_i   = i.irq[0];
        bus.mstatus_mie_i = i.mie;
        bus.mtvec_i       = i.mtvec;
        bus.mepc_i        = i.mepc;
    endtask

    task automatic check(input string n, input ctl_t c, input dat_t d);
        ctl_t ac;
        dat_t ad;
        ac = ct(bus.kill_wb_o,
                {bus.set_mcause_o, bus.set_mepc_o, bus.set_mtval_o, bus.ecall_en_o},
                bus.mret_en_o, bus.flush_o, bus.redirect_valid_o, bus.redirect_pc_o,
                bus.busy_o);
        ad = dt(1'b1, bus.ie_type_o, bus.exception_code_o, bus.epc_o, bus.mtval_o);
        total++;
        if (ac !== c) begin
            bad++;
            $display("FAIL %s ctl got=%h want=%h", n, ac, c);
        end
        if (d.chk) begin
            total++;
            if (ad !== d) begin
                bad++;
                $display("FAIL %s data got=%h want=%h", n, ad, d);
            end
        end
    endtask

    // One cycle: drive at the falling edge, sample shortly after
    task automatic cyc(input string n, input in_t i, input ctl_t c, input dat_t d);
        @(negedge clk);
        apply(i);
        #1;
        check(n, c, d);
    endtask

    vec_t tbl[12];

    initial begin
        in_t  i0;
        ctl_t c0, ck, ce;
        dat_t dskip, d_exc2, d_exc5, d_tmr, d_ei;

        total = 0;
        bad   = 0;

        i0     = ev(1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h50, 3'b000, 1'b1, 32'h200);
        c0     = '0;
        ck     = ct(1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        ce     = ct(1'b0, 4'hF, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        dskip  = '0;
        d_exc2 = dt(1'b1, 1'b0, 4'd2, 32'h100, 32'hDEAD);
        d_exc5 = dt(1'b1, 1'b0, 4'd5, 32'h400, 32'h44);

        tbl[0]  = '{"reset_idle", i0, c0, dt(1'b1, 1'b0, 4'd0, 32'h0, 32'h0)};
        tbl[1]  = '{"exc_accept",
                    ev(1'b1, 4'd2, 32'h100, 32'hDEAD, 1'b0, 1'b1, 32'h50, 3'b000, 1'b1, 32'h200),
                    ck, dt(1'b1, 1'b0, 4'd0, 32'h0, 32'h0)};
        tbl[2]  = '{"exc_enter", i0, ce, d_exc2};
        tbl[3]  = '{"exc_vector", i0, ct(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 32'h200, 1'b1), d_exc2};
        tbl[4]  = '{"exc_idle", i0, c0, d_exc2};
        tbl[5]  = '{"mret_accept",
                    ev(1'b0, 4'd0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h50, 3'b000, 1'b1, 32'h200),
                    ck, dskip};
        tbl[6]  = '{"mret_return", i0, ct(1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 32'h104, 1'b1), dskip};
        tbl[7]  = '{"mret_idle", i0, c0, dskip};
        tbl[8]  = '{"exc_mret_accept",
                    ev(1'b1, 4'd5, 32'h400, 32'h44, 1'b1, 1'b1, 32'h50, 3'b000, 1'b1, 32'h200),
                    ck, dskip};
        tbl[9]  = '{"busy_ignore",
                    ev(1'b1, 4'd9, 32'h500, 32'h55, 1'b1, 1'b1, 32'h50, 3'b000, 1'b1, 32'h200),
                    ce, d_exc5};
        tbl[10] = '{"exc_base_vecmode",
                    ev(1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h50, 3'b000, 1'b1, 32'h201),
                    ct(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 32'h200, 1'b1), d_exc5};
        tbl[11] = '{"exc2_idle", i0, c0, d_exc5};

        rst_n = 1'b0;
        apply(i0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 12; k++) begin
            cyc(tbl[k].name, tbl[k].i, tbl[k].c, tbl[k].d);
        end

        // Timer interrupt: two cycles of sync latency, then vectored/base target
        begin
            in_t a, a_off;
            a     = ev(1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h300, 3'b001, 1'b1, 32'h201);
            a_off = ev(1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h300, 3'b000, 1'b0, 32'h201);
            d_tmr = dt(1'b1, 1'b1, 4'd7, 32'h300, 32'h0);
            cyc("tmr_sync1", a, c0, d_exc5);
            cyc("tmr_sync2", a, c0, d_exc5);
            cyc("tmr_accept", a, ck, d_exc5);
            cyc("tmr_enter", a_off, ce, d_tmr);
            cyc("tmr_vector", a_off, ct(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, C_TMR_TGT, 1'b1), d_tmr);
            cyc("tmr_idle", a_off, c0, d_tmr);
        end

        // All irqs pending under MIE=0, exception wins, then ext, bubble wait, then sw
        begin
            in_t m0, x, bub, b1, e_off, s_on, s_off;
            m0    = ev(1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h700, 3'b111, 1'b0, 32'h200);
            x     = ev(1'b1, 4'd4, 32'h600, 32'h66, 1'b0, 1'b1, 32'h700, 3'b111, 1'b1, 32'h200);
            bub   = ev(1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h700, 3'b111, 1'b1, 32'h200);
            b1    = ev(1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h704, 3'b111, 1'b1, 32'h200);
            e_off = ev(1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h708, 3'b011, 1'b0, 32'h200);
            s_on  = ev(1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h70C, 3'b011, 1'b1, 32'h200);
            s_off = ev(1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h710, 3'b000, 1'b0, 32'h200);
            d_ei  = dt(1'b1, 1'b0, 4'd4, 32'h600, 32'h66);
            cyc("mie0_wait1", m0, c0, d_tmr);
            cyc("mie0_wait2", m0, c0, d_tmr);
            cyc("mie0_wait3", m0, c0, d_tmr);
            cyc("exc_irq_accept", x, ck, d_tmr);
            cyc("exc_irq_enter", m0, ce, d_ei);
            cyc("exc_irq_vector", m0, ct(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 32'h200, 1'b1), d_ei);
            cyc("irq_bubble", bub, c0, d_ei);
            cyc("ext_accept", b1, ck, d_ei);
            cyc("ext_enter", e_off, ce, dt(1'b1, 1'b1, 4'd11, 32'h704, 32'h0));
            cyc("ext_vector", e_off, ct(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 32'h200, 1'b1),
                dt(1'b1, 1'b1, 4'd11, 32'h704, 32'h0));
            cyc("sw_wait", e_off, c0, dt(1'b1, 1'b1, 4'd11, 32'h704, 32'h0));
            cyc("sw_accept", s_on, ck, dt(1'b1, 1'b1, 4'd11, 32'h704, 32'h0));
            cyc("sw_enter", s_off, ce, dt(1'b1, 1'b1, 4'd3, 32'h70C, 32'h0));
            cyc("sw_vector", s_off, ct(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 32'h200, 1'b1),
                dt(1'b1, 1'b1, 4'd3, 32'h70C, 32'h0));
            cyc("sw_idle", s_off, c0, dt(1'b1, 1'b1, 4'd3, 32'h70C, 32'h0));
        end

        // Asynchronous reset in ENTER clears everything and no redirect follows
        begin
            in_t r0;
            r0 = ev(1'b1, 4'd1, 32'h800, 32'h88, 1'b0, 1'b1, 32'h50, 3'b000, 1'b0, 32'h200);
            cyc("rst_accept", r0, ck, dt(1'b1, 1'b1, 4'd3, 32'h70C, 32'h0));
            cyc("rst_enter", i0, ce, dt(1'b1, 1'b0, 4'd1, 32'h800, 32'h88));
            #1 rst_n = 1'b0;
            #1 check("rst_async", c0, dt(1'b1, 1'b0, 4'd0, 32'h0, 32'h0));
            @(negedge clk);
            rst_n = 1'b1;
            cyc("rst_post1", i0, c0, dt(1'b1, 1'b0, 4'd0, 32'h0, 32'h0));
            cyc("rst_post2", i0, c0, dt(1'b1, 1'b0, 4'd0, 32'h0, 32'h0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_trap_ctrl
`default_nettype wire
